// File: rtl/avmm_ccip_host_arbiter.sv
// Two-master Avalon-MM arbiter in front of avmm_ccip_host: round-robin grant, write-burst
// locking and a tag FIFO that steers in-order read beats back to the issuing master.
module avmm_ccip_host_arbiter #(
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned ADDR_WIDTH     = 49,
    parameter int unsigned BURST_WIDTH    = 3,
    parameter int unsigned TAG_FIFO_DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     m0_address,
    input  logic                      m0_read,
    input  logic                      m0_write,
    input  logic [BURST_WIDTH-1:0]    m0_burstcount,
    input  logic [DATA_WIDTH-1:0]     m0_writedata,
    input  logic [DATA_WIDTH/8-1:0]   m0_byteenable,
    output logic                      m0_waitrequest,
    output logic [DATA_WIDTH-1:0]     m0_readdata,
    output logic                      m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]     m1_address,
    input  logic                      m1_read,
    input  logic                      m1_write,
    input  logic [BURST_WIDTH-1:0]    m1_burstcount,
    input  logic [DATA_WIDTH-1:0]     m1_writedata,
    input  logic [DATA_WIDTH/8-1:0]   m1_byteenable,
    output logic                      m1_waitrequest,
    output logic [DATA_WIDTH-1:0]     m1_readdata,
    output logic                      m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0]     h_address,
    output logic                      h_read,
    output logic                      h_write,
    output logic [BURST_WIDTH-1:0]    h_burstcount,
    output logic [DATA_WIDTH-1:0]     h_writedata,
    output logic [DATA_WIDTH/8-1:0]   h_byteenable,
    input  logic                      h_waitrequest,
    input  logic [DATA_WIDTH-1:0]     h_readdata,
    input  logic                      h_readdatavalid,
    output logic                      err_unexpected_rsp
);
    localparam int unsigned PTR_WIDTH = $clog2(TAG_FIFO_DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

    typedef enum logic {IDLE = 1'b0, WR_LOCK = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic [BURST_WIDTH-1:0]  wr_left_q, wr_left_d;
    logic [PTR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [BURST_WIDTH-1:0]  rsp_cnt_q, rsp_cnt_d;
    logic                    err_q, err_d;
    logic                    m0_rdv_q, m0_rdv_d, m1_rdv_q, m1_rdv_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    tag_id_mem    [TAG_FIFO_DEPTH];
    logic [BURST_WIDTH-1:0]  tag_beats_mem [TAG_FIFO_DEPTH];

    logic                    fifo_empty, tag_full, pop, push, accept;
    logic                    head_id;
    logic [BURST_WIDTH-1:0]  head_beats, sel_beats;
    logic                    req0, req1, sel_valid, sel_id, sel_read, sel_write;

    // Illegal burst lengths (0, 3, >4) collapse to a single beat.
    function automatic logic [BURST_WIDTH-1:0] norm_beats(input logic [BURST_WIDTH-1:0] bc);
        if (bc == BURST_WIDTH'(2) || bc == BURST_WIDTH'(4)) return bc;
        return BURST_WIDTH'(1);
    endfunction

    // Tag FIFO status; a completing beat frees its slot for a read in the same cycle.
    always_comb begin
        fifo_empty = (count_q == '0);
        head_id    = tag_id_mem[rd_ptr_q];
        head_beats = tag_beats_mem[rd_ptr_q];
        pop        = h_readdatavalid & ~fifo_empty & (rsp_cnt_q == head_beats - BURST_WIDTH'(1));
        tag_full   = (count_q == CNT_WIDTH'(TAG_FIFO_DEPTH)) & ~pop;
    end

    // Grant selection and combinational command mux.
    always_comb begin
        req0      = m0_write | (m0_read & ~tag_full);
        req1      = m1_write | (m1_read & ~tag_full);
        sel_valid = 1'b0;
        sel_id    = 1'b0;
        if (state_q == WR_LOCK) begin
            sel_valid = 1'b1;
            sel_id    = owner_q;
        end else if (req0 & req1) begin
            sel_valid = 1'b1;
            sel_id    = ~last_grant_q;
        end else if (req0 | req1) begin
            sel_valid = 1'b1;
            sel_id    = req1;
        end
        sel_read     = sel_id ? m1_read  : m0_read;
        sel_write    = sel_id ? m1_write : m0_write;
        h_address    = sel_id ? m1_address    : m0_address;
        h_burstcount = sel_id ? m1_burstcount : m0_burstcount;
        h_writedata  = sel_id ? m1_writedata  : m0_writedata;
        h_byteenable = sel_id ? m1_byteenable : m0_byteenable;
        h_read       = sel_valid & sel_read & (state_q == IDLE) & ~tag_full;
        h_write      = sel_valid & sel_write;
        accept       = (h_read | h_write) & ~h_waitrequest;
        push         = accept & h_read;
        sel_beats    = norm_beats(h_burstcount);
        m0_waitrequest = ~(sel_valid & ~sel_id) | h_waitrequest
                       | (m0_read & tag_full & (state_q == IDLE));
        m1_waitrequest = ~(sel_valid & sel_id) | h_waitrequest
                       | (m1_read & tag_full & (state_q == IDLE));
    end

    // Next-state: lock tracking, FIFO pointers and response steering.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wr_left_d    = wr_left_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rsp_cnt_d    = rsp_cnt_q;
        if (accept) last_grant_d = sel_id;
        if (state_q == IDLE) begin
            if (accept & h_write & (sel_beats != BURST_WIDTH'(1))) begin
                state_d   = WR_LOCK;
                owner_d   = sel_id;
                wr_left_d = sel_beats - BURST_WIDTH'(1);
            end
        end else if (accept) begin
            wr_left_d = wr_left_q - BURST_WIDTH'(1);
            if (wr_left_q == BURST_WIDTH'(1)) state_d = IDLE;
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_WIDTH'(1);
            rsp_cnt_d = '0;
        end else if (h_readdatavalid & ~fifo_empty) begin
            rsp_cnt_d = rsp_cnt_q + BURST_WIDTH'(1);
        end
        count_d  = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        err_d    = err_q | (h_readdatavalid & fifo_empty);
        m0_rdv_d = h_readdatavalid & ~fifo_empty & ~head_id;
        m1_rdv_d = h_readdatavalid & ~fifo_empty & head_id;
        rdata_d  = h_readdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wr_left_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_cnt_q    <= '0;
            err_q        <= 1'b0;
            m0_rdv_q     <= 1'b0;
            m1_rdv_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wr_left_q    <= wr_left_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_cnt_q    <= rsp_cnt_d;
            err_q        <= err_d;
            m0_rdv_q     <= m0_rdv_d;
            m1_rdv_q     <= m1_rdv_d;
            rdata_q      <= rdata_d;
        end
    end

    // Tag storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_id_mem[wr_ptr_q]    <= sel_id;
            tag_beats_mem[wr_ptr_q] <= sel_beats;
        end
    end

    assign m0_readdata        = rdata_q;
    assign m1_readdata        = rdata_q;
    assign m0_readdatavalid   = m0_rdv_q;
    assign m1_readdatavalid   = m1_rdv_q;
    assign err_unexpected_rsp = err_q;
endmodule

// File: tb/tb_avmm_ccip_host_arbiter.sv
// Bench for avmm_ccip_host_arbiter: directed scenarios plus randomized arbitration, checked
// against a transaction-level model of grants and in-order read-beat ownership.
module tb_avmm_ccip_host_arbiter;
    localparam int unsigned DW = 512;
    localparam int unsigned AW = 49;
    localparam int unsigned BW = 3;

    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] m0_address, m1_address, h_address;
    logic m0_read, m0_write, m1_read, m1_write, h_read, h_write;
    logic [BW-1:0] m0_burstcount, m1_burstcount, h_burstcount;
    logic [DW-1:0] m0_writedata, m1_writedata, h_writedata;
    logic [DW/8-1:0] m0_byteenable, m1_byteenable, h_byteenable;
    logic m0_waitrequest, m1_waitrequest, h_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata, h_readdata;
    logic m0_readdatavalid, m1_readdatavalid, h_readdatavalid;
    logic err_unexpected_rsp;

    int checks = 0;
    int failures = 0;
    int q_id[$];
    int q_left[$];
    bit lg;

    always #5 clk = ~clk;

    avmm_ccip_host_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_burstcount(m1_burstcount), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .h_address(h_address), .h_read(h_read), .h_write(h_write), .h_burstcount(h_burstcount),
        .h_writedata(h_writedata), .h_byteenable(h_byteenable), .h_waitrequest(h_waitrequest),
        .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid),
        .err_unexpected_rsp(err_unexpected_rsp)
    );

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return AW'({$urandom, $urandom});
    endfunction

    function automatic int nbeats(input logic [BW-1:0] bc);
        return (bc == 3'd2 || bc == 3'd4) ? int'(bc) : 1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        h_readdatavalid = 0; h_waitrequest = 0;
    endtask

    // One host read beat; the model names the master that must see it a cycle later.
    task automatic resp_beat(input logic [DW-1:0] d);
        int id;
        cyc();
        h_readdatavalid = 1; h_readdata = d;
        id = q_id[0];
        q_left[0] = q_left[0] - 1;
        if (q_left[0] == 0) begin
            void'(q_id.pop_front());
            void'(q_left.pop_front());
        end
        cyc();
        h_readdatavalid = 0;
        #1;
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== (id == 0 ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL resp_owner got rdv=%b exp id=%0d", {m0_readdatavalid, m1_readdatavalid}, id);
        end
        checks++;
        if ((id == 0 ? m0_readdata : m1_readdata) !== d) begin
            failures++;
            $display("FAIL resp_data got=%h exp=%h", (id == 0 ? m0_readdata : m1_readdata), d);
        end
    endtask

    task automatic test_reset();
        reset = 1; idle(); h_waitrequest = 1;
        m0_address = '0; m1_address = '0; m0_burstcount = 1; m1_burstcount = 1;
        m0_writedata = '0; m1_writedata = '0; m0_byteenable = '1; m1_byteenable = '1; h_readdata = '0;
        cyc(); cyc();
        reset = 0;
        cyc();
        checks++;
        if ({h_read, h_write, m0_readdatavalid, m1_readdatavalid, err_unexpected_rsp, m0_waitrequest, m1_waitrequest} !== 7'b0000011) begin
            failures++;
            $display("FAIL reset_state got=%b exp=0000011", {h_read, h_write, m0_readdatavalid, m1_readdatavalid, err_unexpected_rsp, m0_waitrequest, m1_waitrequest});
        end
        h_waitrequest = 0;
        #1;
        checks++;
        if ({h_read, h_write, err_unexpected_rsp} !== 3'b000) begin
            failures++;
            $display("FAIL idle_cmd got=%b exp=000", {h_read, h_write, err_unexpected_rsp});
        end
        lg = 1;
        q_id.delete(); q_left.delete();
    endtask

    task automatic test_dual_read();
        logic [AW-1:0] a0, a1;
        logic [DW/8-1:0] be;
        a0 = rnd_addr(); a1 = rnd_addr(); be = {16{$urandom}};
        cyc();
        m0_read = 1; m0_address = a0; m0_burstcount = 2; m0_byteenable = be;
        m1_read = 1; m1_address = a1; m1_burstcount = 2;
        #1;
        checks++;
        if ({h_read, m0_waitrequest, m1_waitrequest} !== 3'b101 || h_address !== a0 || h_byteenable !== be) begin
            failures++;
            $display("FAIL dual_first got rd=%b w0=%b w1=%b addr=%h exp addr=%h", h_read, m0_waitrequest, m1_waitrequest, h_address, a0);
        end
        q_id.push_back(0); q_left.push_back(2); lg = 0;
        cyc();
        m0_read = 0;
        #1;
        checks++;
        if ({h_read, m1_waitrequest} !== 2'b10 || h_address !== a1) begin
            failures++;
            $display("FAIL dual_second got rd=%b w1=%b addr=%h exp addr=%h", h_read, m1_waitrequest, h_address, a1);
        end
        q_id.push_back(1); q_left.push_back(2); lg = 1;
        cyc();
        m1_read = 0;
        for (int i = 0; i < 4; i++) resp_beat(rnd_data());
    endtask

    task automatic test_write_lock();
        logic [AW-1:0] b0, b1;
        logic [DW-1:0] wd;
        int beats = 0;
        int k = 0;
        b0 = rnd_addr(); b1 = rnd_addr();
        while (beats < 4 && k < 20) begin
            cyc();
            wd = rnd_data();
            m0_write = 1; m0_address = b0; m0_burstcount = 4; m0_writedata = wd;
            m1_write = 1; m1_address = b1; m1_burstcount = 1;
            h_waitrequest = k[0];
            #1;
            checks++;
            if ({h_write, m0_waitrequest, m1_waitrequest} !== {1'b1, h_waitrequest, 1'b1} || h_address !== b0 || h_writedata !== wd) begin
                failures++;
                $display("FAIL lock_owner beat=%0d got wr=%b w0=%b w1=%b addr=%h exp addr=%h", beats, h_write, m0_waitrequest, m1_waitrequest, h_address, b0);
            end
            if (!h_waitrequest) beats++;
            k++;
        end
        checks++;
        if (beats != 4) begin
            failures++;
            $display("FAIL lock_budget got beats=%0d exp=4", beats);
        end
        lg = 0;
        cyc();
        m0_write = 0; h_waitrequest = 0;
        #1;
        checks++;
        if ({h_write, m1_waitrequest} !== 2'b10 || h_address !== b1) begin
            failures++;
            $display("FAIL lock_release got wr=%b w1=%b addr=%h exp addr=%h", h_write, m1_waitrequest, h_address, b1);
        end
        lg = 1;
        cyc();
        m1_write = 0;
    endtask

    task automatic test_fill();
        logic [AW-1:0] r, w;
        logic [DW-1:0] d;
        int ok = 1;
        for (int i = 0; i < 64; i++) begin
            cyc();
            m0_read = 1; m0_burstcount = 1; m0_address = rnd_addr();
            #1;
            if (m0_waitrequest !== 1'b0 || h_read !== 1'b1) ok = 0;
            q_id.push_back(0); q_left.push_back(1);
        end
        lg = 0;
        checks++;
        if (ok == 0) begin
            failures++;
            $display("FAIL fill_accept got stall before 64 exp none");
        end
        r = rnd_addr(); w = rnd_addr();
        cyc();
        m0_address = r; m1_write = 1; m1_address = w; m1_burstcount = 1;
        #1;
        checks++;
        if ({m0_waitrequest, h_read, h_write, m1_waitrequest} !== 4'b1010 || h_address !== w) begin
            failures++;
            $display("FAIL full_stall got w0=%b rd=%b wr=%b w1=%b exp 1010", m0_waitrequest, h_read, h_write, m1_waitrequest);
        end
        lg = 1;
        d = rnd_data();
        cyc();
        m1_write = 0; h_readdatavalid = 1; h_readdata = d;
        #1;
        checks++;
        if ({m0_waitrequest, h_read} !== 2'b01 || h_address !== r) begin
            failures++;
            $display("FAIL pop_accept got w0=%b rd=%b addr=%h exp addr=%h", m0_waitrequest, h_read, h_address, r);
        end
        void'(q_id.pop_front()); void'(q_left.pop_front());
        q_id.push_back(0); q_left.push_back(1); lg = 0;
        cyc();
        m0_read = 0; h_readdatavalid = 0;
        #1;
        checks++;
        if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== d) begin
            failures++;
            $display("FAIL pop_beat got rdv=%b%b exp 10", m0_readdatavalid, m1_readdatavalid);
        end
        while (q_id.size() > 0) resp_beat(rnd_data());
    endtask

    task automatic test_unexpected();
        cyc();
        h_readdatavalid = 1; h_readdata = rnd_data();
        cyc();
        h_readdatavalid = 0;
        #1;
        checks++;
        if ({err_unexpected_rsp, m0_readdatavalid, m1_readdatavalid} !== 3'b100) begin
            failures++;
            $display("FAIL unexpected got=%b exp=100", {err_unexpected_rsp, m0_readdatavalid, m1_readdatavalid});
        end
        cyc(); cyc(); cyc();
        checks++;
        if (err_unexpected_rsp !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b exp=1", err_unexpected_rsp);
        end
    endtask

    task automatic test_reset_mid_lock();
        logic [AW-1:0] x;
        for (int i = 0; i < 3; i++) begin
            cyc();
            m0_read = 1; m0_burstcount = 1; m0_address = rnd_addr();
        end
        cyc();
        m0_read = 0; m0_write = 1; m0_burstcount = 4;
        cyc();
        m0_write = 0;
        reset = 1;
        cyc();
        reset = 0;
        q_id.delete(); q_left.delete(); lg = 1;
        x = rnd_addr();
        m1_read = 1; m1_address = x; m1_burstcount = 2;
        #1;
        checks++;
        if ({h_read, m1_waitrequest, err_unexpected_rsp} !== 3'b100 || h_address !== x) begin
            failures++;
            $display("FAIL post_reset got rd=%b w1=%b err=%b addr=%h exp addr=%h", h_read, m1_waitrequest, err_unexpected_rsp, h_address, x);
        end
        q_id.push_back(1); q_left.push_back(2);
        cyc();
        m1_read = 0;
        resp_beat(rnd_data());
        resp_beat(rnd_data());
    endtask

    task automatic test_random();
        logic act[2];
        logic wr[2];
        logic [AW-1:0] ad[2];
        logic [BW-1:0] bc[2];
        logic [BW-1:0] wtab[3];
        int s;
        logic ew0, ew1;
        wtab[0] = 0; wtab[1] = 1; wtab[2] = 3;
        act[0] = 0; act[1] = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(0, 1) == 1) begin
                    act[m] = 1;
                    wr[m] = ($urandom_range(0, 3) == 0);
                    ad[m] = rnd_addr();
                    bc[m] = wr[m] ? wtab[$urandom_range(0, 2)] : BW'($urandom_range(0, 4));
                end
            end
            m0_read = act[0] & ~wr[0]; m0_write = act[0] & wr[0]; m0_address = ad[0]; m0_burstcount = bc[0];
            m1_read = act[1] & ~wr[1]; m1_write = act[1] & wr[1]; m1_address = ad[1]; m1_burstcount = bc[1];
            h_waitrequest = ($urandom_range(0, 3) == 0);
            #1;
            s = -1;
            if (act[0] && act[1]) s = lg ? 0 : 1;
            else if (act[0]) s = 0;
            else if (act[1]) s = 1;
            ew0 = (s != 0) || h_waitrequest;
            ew1 = (s != 1) || h_waitrequest;
            checks++;
            if ({h_read, h_write, m0_waitrequest, m1_waitrequest} !== {s >= 0 && !wr[s], s >= 0 && wr[s], ew0, ew1}) begin
                failures++;
                $display("FAIL rand_grant cyc=%0d got=%b exp sel=%0d", i, {h_read, h_write, m0_waitrequest, m1_waitrequest}, s);
            end
            if (s >= 0) begin
                checks++;
                if (h_address !== ad[s] || h_burstcount !== bc[s]) begin
                    failures++;
                    $display("FAIL rand_mux cyc=%0d got addr=%h exp=%h", i, h_address, ad[s]);
                end
                if (!h_waitrequest) begin
                    if (!wr[s]) begin
                        q_id.push_back(s); q_left.push_back(nbeats(bc[s]));
                    end
                    lg = s[0];
                    act[s] = 0;
                end
            end
        end
        cyc();
        idle();
        while (q_id.size() > 0) resp_beat(rnd_data());
    endtask

    initial begin
        test_reset();
        test_dual_read();
        test_write_lock();
        test_fill();
        test_unexpected();
        test_reset_mid_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
